// File: rtl/spi_cmd_if.sv
// Signal bundle between the SPI command sequencer and its environment:
// the SPI byte link (rx/tx) and the single-byte memory/register port.
interface spi_cmd_if #(
    parameter int ADDR_W = 16
);
    logic              frame;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              busy;

    // Sequencer side.
    modport master (
        input  frame, rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        output tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    // SPI link / memory side.
    modport slave (
        output frame, rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        input  tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns each chip-select frame (cmd, addr, data)
// into single-byte memory reads/writes, paces read data into the SPI
// transmitter and keeps sticky overrun / bad-command flags.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no frame in progress; first byte of a frame is the command
// S_ADDR_HI  | waiting for the address high byte
// S_ADDR_LO  | waiting for the address low byte
// S_WR_DATA  | waiting for the next write data byte
// S_WR_MEM   | write request outstanding
// S_RD_FETCH | read request outstanding
// S_RD_SEND  | read byte offered to the transmitter
// S_ST_SEND  | status byte offered to the transmitter
// S_DRAIN    | rest of the frame ignored until chip-select drops
// S_FLUSH    | frame ended with a request outstanding; wait for the ack
module spi_cmd_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic      clk_i,
    input  logic      reset_i,
    spi_cmd_if.master bus
);
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WR_DATA,
        S_WR_MEM,
        S_RD_FETCH,
        S_RD_SEND,
        S_ST_SEND,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              bad_cmd_q, bad_cmd_d;

    logic              tx_xfer;
    logic              ack_done;
    logic [ADDR_W-1:0] addr_inc;

    assign tx_xfer  = tx_valid_q & bus.tx_ready;
    assign ack_done = req_q & bus.mem_ack;
    assign addr_inc = addr_q + ADDR_W'(1);

    // Next-state, output and flag logic.
    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        req_d      = req_q;
        we_d       = we_q;
        overrun_d  = overrun_q;
        bad_cmd_d  = bad_cmd_q;

        // Reading the status clears the flags; any set below overrides this.
        if (state_q == S_ST_SEND && tx_xfer) begin
            overrun_d = 1'b0;
            bad_cmd_d = 1'b0;
        end

        if (state_q != S_IDLE && !bus.frame) begin
            // Frame over: finish an outstanding access first, drop any read data.
            tx_valid_d = 1'b0;
            if (req_q && !bus.mem_ack) begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                if (ack_done) begin
                    addr_d = addr_inc;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame && bus.rx_valid) begin
                        case (bus.rx_data)
                            CMD_WRITE: begin
                                is_read_d = 1'b0;
                                state_d   = S_ADDR_HI;
                            end
                            CMD_READ: begin
                                is_read_d = 1'b1;
                                state_d   = S_ADDR_HI;
                            end
                            CMD_STATUS: begin
                                tx_data_d  = {overrun_q, bad_cmd_q, 6'b0};
                                tx_valid_d = 1'b1;
                                state_d    = S_ST_SEND;
                            end
                            default: begin
                                bad_cmd_d = 1'b1;
                                state_d   = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_ADDR_HI: begin
                    if (bus.rx_valid) begin
                        addr_d[ADDR_W-1:8] = bus.rx_data[ADDR_W-9:0];
                        state_d            = S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (bus.rx_valid) begin
                        addr_d[7:0] = bus.rx_data;
                        if (is_read_q) begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            state_d = S_RD_FETCH;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (bus.rx_valid) begin
                        wdata_d = bus.rx_data;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = S_WR_MEM;
                    end
                end
                S_WR_MEM: begin
                    if (bus.rx_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.mem_ack) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = addr_inc;
                        state_d = S_WR_DATA;
                    end
                end
                S_RD_FETCH: begin
                    if (bus.mem_ack) begin
                        tx_data_d  = bus.mem_rdata;
                        tx_valid_d = 1'b1;
                        req_d      = 1'b0;
                        addr_d     = addr_inc;
                        state_d    = S_RD_SEND;
                    end
                end
                S_RD_SEND: begin
                    if (tx_xfer) begin
                        tx_valid_d = 1'b0;
                        req_d      = 1'b1;
                        we_d       = 1'b0;
                        state_d    = S_RD_FETCH;
                    end
                end
                S_ST_SEND: begin
                    if (tx_xfer) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    tx_valid_d = 1'b0;
                end
                S_FLUSH: begin
                    if (bus.mem_ack) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = addr_inc;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            bad_cmd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            req_q      <= req_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            bad_cmd_q  <= bad_cmd_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: a byte-array memory model answers requests with a
// programmable ack delay, expected writes/reads/tx bytes are queued by the
// directed tests and checked cycle by cycle by one compare process.
module tb_spi_cmd_ctrl;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic reset;

    spi_cmd_if #(.ADDR_W(ADDR_W)) bus ();

    spi_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int tx_count    = 0;
    int tx_budget   = 0;
    int req_rises   = 0;
    int ack_delay   = 0;

    logic [7:0]  mem_model [65536];
    logic [15:0] exp_wr_addr [$];
    logic [7:0]  exp_wr_data [$];
    logic [15:0] exp_rd      [$];
    logic [7:0]  exp_tx      [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] b);
        send_byte(b);
        idle(7);
    endtask

    task automatic frame_begin();
        @(posedge clk);
        #1;
        bus.frame = 1'b1;
    endtask

    task automatic frame_end();
        @(posedge clk);
        #1;
        bus.frame    = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        for (int k = 0; k < 300; k++) begin
            if (tx_count >= n) break;
            sample();
        end
        check(name, 32'(tx_count), 32'(n));
    endtask

    task automatic end_test(input string name);
        check({name, "_wr_left"}, 32'(exp_wr_addr.size()), 32'h0);
        check({name, "_rd_left"}, 32'(exp_rd.size()), 32'h0);
        check({name, "_tx_left"}, 32'(exp_tx.size()), 32'h0);
    endtask

    task automatic do_status(input logic [7:0] expv, input string name);
        int base;
        base      = tx_count;
        tx_budget = 1;
        exp_tx.push_back(expv);
        frame_begin();
        send_byte(8'h05);
        wait_tx(base + 1, {name, "_sent"});
        idle(3);
        frame_end();
        idle(2);
        sample();
        check({name, "_busy_end"}, 32'(bus.busy), 32'h0);
    endtask

    // Memory responder: ack ack_delay cycles after the request is seen.
    bit waiting;
    int ack_cnt;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        waiting       = 1'b0;
        ack_cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (reset || !bus.mem_req) begin
                waiting = 1'b0;
            end else begin
                if (!waiting) begin
                    waiting = 1'b1;
                    ack_cnt = ack_delay;
                end
                if (ack_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    waiting     = 1'b0;
                    if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = mem_model[bus.mem_addr];
                end else begin
                    ack_cnt--;
                end
            end
        end
    end

    // Transmitter: consumes up to tx_budget bytes.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = (tx_budget > 0) && bus.tx_valid;
        end
    end

    // Compare process.
    logic        prev_req;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wdata;
    logic [15:0] cmp_a;
    logic [7:0]  cmp_d;
    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_req && bus.mem_req) begin
                    check("req_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
                    check("req_we_stable", 32'(bus.mem_we), 32'(prev_we));
                    check("req_wdata_stable", 32'(bus.mem_wdata), 32'(prev_wdata));
                end
                if (bus.mem_req && !prev_req) req_rises++;
                if (bus.mem_req && bus.mem_ack) begin
                    if (bus.mem_we) begin
                        if (exp_wr_addr.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", bus.mem_addr, bus.mem_wdata);
                        end else begin
                            cmp_a = exp_wr_addr.pop_front();
                            cmp_d = exp_wr_data.pop_front();
                            check("wr_addr", 32'(bus.mem_addr), 32'(cmp_a));
                            check("wr_data", 32'(bus.mem_wdata), 32'(cmp_d));
                        end
                    end else begin
                        if (exp_rd.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_read: got addr 0x%0h, expected none", bus.mem_addr);
                        end else begin
                            cmp_a = exp_rd.pop_front();
                            check("rd_addr", 32'(bus.mem_addr), 32'(cmp_a));
                        end
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    tx_count++;
                    if (tx_budget > 0) tx_budget--;
                    if (exp_tx.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_tx: got 0x%0h, expected none", bus.tx_data);
                    end else begin
                        cmp_d = exp_tx.pop_front();
                        check("tx_data", 32'(bus.tx_data), 32'(cmp_d));
                    end
                end
            end
            prev_req   = bus.mem_req;
            prev_we    = bus.mem_we;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset        = 1'b1;
        bus.frame    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
        idle(3);
        sample();
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // WRITE 0x1234 <- A5, 5A with ack 2 cycles after request.
        ack_delay = 2;
        exp_wr_addr.push_back(16'h1234); exp_wr_data.push_back(8'hA5);
        exp_wr_addr.push_back(16'h1235); exp_wr_data.push_back(8'h5A);
        frame_begin();
        send_spaced(8'h01);
        send_spaced(8'h12);
        send_spaced(8'h34);
        send_byte(8'hA5);
        sample();
        check("wr_req_rise", 32'(bus.mem_req), 32'h1);
        check("wr_req_we", 32'(bus.mem_we), 32'h1);
        check("wr_req_addr", 32'(bus.mem_addr), 32'h1234);
        idle(8);
        send_spaced(8'h5A);
        frame_end();
        idle(2);
        sample();
        check("wr_busy_end", 32'(bus.busy), 32'h0);
        check("wr_mem_1234", 32'(mem_model[16'h1234]), 32'hA5);
        check("wr_mem_1235", 32'(mem_model[16'h1235]), 32'h5A);
        end_test("write");

        // READ from 0xFFFF with wrap; two bytes consumed, third fetch at 0x0001.
        ack_delay = 1;
        mem_model[16'hFFFF] = 8'h11;
        mem_model[16'h0000] = 8'h22;
        mem_model[16'h0001] = 8'h33;
        exp_rd.push_back(16'hFFFF);
        exp_rd.push_back(16'h0000);
        exp_rd.push_back(16'h0001);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        base      = tx_count;
        tx_budget = 2;
        frame_begin();
        send_spaced(8'h02);
        send_spaced(8'hFF);
        send_byte(8'hFF);
        sample();
        check("rd_req_rise", 32'(bus.mem_req), 32'h1);
        check("rd_req_we", 32'(bus.mem_we), 32'h0);
        check("rd_req_addr", 32'(bus.mem_addr), 32'hFFFF);
        wait_tx(base + 2, "rd_two_sent");
        sample();
        check("rd_next_req", 32'(bus.mem_req), 32'h1);
        check("rd_next_addr", 32'(bus.mem_addr), 32'h0001);
        idle(4);
        frame_end();
        idle(2);
        sample();
        check("rd_busy_end", 32'(bus.busy), 32'h0);
        check("rd_txv_end", 32'(bus.tx_valid), 32'h0);
        end_test("read");

        // Overrun: second data byte arrives while the first write is pending.
        ack_delay = 20;
        tx_budget = 0;
        exp_wr_addr.push_back(16'h0010); exp_wr_data.push_back(8'hAA);
        frame_begin();
        send_spaced(8'h01);
        send_spaced(8'h00);
        send_spaced(8'h10);
        send_byte(8'hAA);
        idle(8);
        send_byte(8'hBB);
        idle(25);
        frame_end();
        idle(2);
        check("ovr_mem_0010", 32'(mem_model[16'h0010]), 32'hAA);
        check("ovr_mem_0011", 32'(mem_model[16'h0011]), 32'h00);
        do_status(8'h80, "status_ovr");
        do_status(8'h00, "status_clr");
        end_test("overrun");

        // Bad command: no memory traffic, bad_cmd flag reported.
        base = req_rises;
        frame_begin();
        send_spaced(8'h7E);
        send_spaced(8'h01);
        send_spaced(8'h02);
        send_byte(8'h03);
        sample();
        check("bad_busy_drain", 32'(bus.busy), 32'h1);
        frame_end();
        idle(2);
        check("bad_no_req", 32'(req_rises), 32'(base));
        do_status(8'h40, "status_bad");
        end_test("badcmd");

        // Frame dropped during RD_FETCH; request held until a late ack.
        ack_delay = 3;
        tx_budget = 5;
        mem_model[16'h0020] = 8'h77;
        exp_rd.push_back(16'h0020);
        frame_begin();
        send_spaced(8'h02);
        send_spaced(8'h00);
        send_byte(8'h20);
        frame_end();
        begin
            bit saw_ack;
            saw_ack = 1'b0;
            for (int k = 0; k < 50; k++) begin
                sample();
                if (bus.mem_ack) begin
                    saw_ack = 1'b1;
                    break;
                end
                check("drop_req_held", 32'(bus.mem_req), 32'h1);
                check("drop_txv_low", 32'(bus.tx_valid), 32'h0);
            end
            check("drop_ack_seen", 32'(saw_ack), 32'h1);
        end
        sample();
        check("drop_req_low", 32'(bus.mem_req), 32'h0);
        check("drop_busy_low", 32'(bus.busy), 32'h0);
        check("drop_txv_end", 32'(bus.tx_valid), 32'h0);
        tx_budget = 0;
        end_test("drop");

        // Following WRITE works normally.
        ack_delay = 0;
        exp_wr_addr.push_back(16'h0040); exp_wr_data.push_back(8'hC3);
        frame_begin();
        send_spaced(8'h01);
        send_spaced(8'h00);
        send_spaced(8'h40);
        send_spaced(8'hC3);
        frame_end();
        idle(2);
        check("post_drop_mem", 32'(mem_model[16'h0040]), 32'hC3);
        end_test("post_drop");

        // Reset during WR_MEM, then a READ frame.
        ack_delay = 20;
        mem_model[16'h0050] = 8'h44;
        mem_model[16'h0051] = 8'h45;
        frame_begin();
        send_spaced(8'h01);
        send_spaced(8'h00);
        send_spaced(8'h50);
        send_byte(8'h99);
        sample();
        check("rst_wr_req", 32'(bus.mem_req), 32'h1);
        idle(3);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.frame = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        check("midrst_tx_data", 32'(bus.tx_data), 32'h0);
        check("midrst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("midrst_mem_req", 32'(bus.mem_req), 32'h0);
        check("midrst_mem_we", 32'(bus.mem_we), 32'h0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("midrst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        ack_delay = 1;
        exp_rd.push_back(16'h0050);
        exp_rd.push_back(16'h0051);
        exp_tx.push_back(8'h44);
        base      = tx_count;
        tx_budget = 1;
        frame_begin();
        send_spaced(8'h02);
        send_spaced(8'h00);
        send_byte(8'h50);
        wait_tx(base + 1, "rst_rd_sent");
        idle(6);
        frame_end();
        idle(2);
        sample();
        check("rst_rd_busy_end", 32'(bus.busy), 32'h0);
        check("rst_mem_0050", 32'(mem_model[16'h0050]), 32'h44);
        end_test("reset_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer on the system side of the SPI slave byte link. Parses each chip-select frame into a command, a 16-bit address and a data stream, and converts it into single-byte read/write transactions on a memory/register port. It paces the read stream into the SPI transmit path. It also keeps sticky error flags that the host reads back over SPI.

## Interface
Parameters:
- ADDR_W, 16, memory address width (9..16); the address bytes supply bits [ADDR_W-1:0], upper bits ignored

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame  in  1  high while SPI chip-select is asserted (already synchronized to clk)
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- tx_data  out  8  byte offered to the SPI transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter consumed tx_data this cycle (transfer = tx_valid & tx_ready)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  8  write data
- mem_ack  in  1  one-cycle completion strobe; mem_rdata valid in the same cycle
- mem_rdata  in  8  read data
- busy  out  1  high in any state other than IDLE

## Operation
- Commands, given by the first byte of a frame:
  - 0x01 WRITE: cmd, addr_hi, addr_lo, then data bytes until the frame ends.
  - 0x02 READ: cmd, addr_hi, addr_lo; data is then streamed out until the frame ends.
  - 0x05 STATUS: cmd; tx_data = {overrun, bad_cmd, 6'b0}.
- Any other command byte: bad_cmd is set and the controller goes to DRAIN.
- States and transitions:
  - IDLE: on rx_valid & frame, go to CMD decode.
  - ADDR_HI, ADDR_LO: capture the address bytes.
  - WR_DATA: on rx_valid, latch the byte into mem_wdata, raise mem_req/mem_we, go to WR_MEM.
  - WR_MEM: on mem_ack, increment the address, go to WR_DATA.
  - RD_FETCH: mem_req with mem_we=0; on mem_ack, latch mem_rdata into tx_data, set tx_valid, increment the address, go to RD_SEND.
  - RD_SEND: on tx_valid & tx_ready, go to RD_FETCH.
  - ST_SEND: drive the status byte; on transfer, clear both flags, go to DRAIN.
  - DRAIN: ignore rx, tx_valid=0, wait for frame low.
- A READ issues its first fetch in the cycle after addr_lo is received.
- The address counter increments by 1 after every completed access and wraps from 2^ADDR_W-1 to 0.
- Overrun: rx_valid while in WR_MEM sets the sticky overrun flag and the byte is dropped. The pending write still completes.
- rx bytes received during READ/STATUS after the command/address are ignored; they carry no meaning.
- Frame end (frame falls):
  - In any state without an outstanding mem_req: go to IDLE next cycle, tx_valid cleared.
  - With mem_req outstanding: hold mem_req until mem_ack, discard read data, then go to IDLE.
- A frame ending before the address is complete issues no memory access.
- rx_valid with frame low is ignored in IDLE.

## Timing
- Reset values: tx_data=0, tx_valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, flags=0, state IDLE.
- Reset mid-transaction drops mem_req immediately; the memory side must tolerate an abandoned request.
- WRITE: mem_req rises 1 cycle after a data-byte rx_valid.
- READ: mem_req rises 1 cycle after the addr_lo rx_valid. tx_valid rises 1 cycle after mem_ack. The next mem_req rises 1 cycle after the tx transfer.
- All outputs are registered; mem_addr/mem_we/mem_wdata do not change while mem_req is high.
- Simultaneous mem_ack and frame fall: the ack completes the access (write counts, read data discarded) and the state is IDLE next cycle.
- Simultaneous ST_SEND transfer and a new flag-setting event: the set wins (the flag stays 1).

## Test plan
- WRITE 0x01,0x12,0x34,0xA5,0x5A with mem_ack 2 cycles after req -> writes 0xA5@0x1234, 0x5A@0x1235; busy=0 after frame end.
- READ 0x02,0xFF,0xFF, memory holds 0x11@0xFFFF and 0x22@0x0000 -> tx stream 0x11, 0x22 (address wrap); next fetch 0x0001 issued after the second transfer.
- WRITE with mem_ack delayed 20 cycles and a second data byte arriving during WR_MEM -> only the first byte is written; then STATUS 0x05 returns 0x80 and a second STATUS returns 0x00.
- Command 0x7E, then three bytes -> no mem_req; STATUS returns 0x40.
- Frame dropped during RD_FETCH with mem_ack 3 cycles later -> mem_req held until ack, tx_valid stays 0, IDLE next cycle; the following WRITE frame works normally.
- Reset asserted during WR_MEM -> all outputs 0 on the next cycle; the following READ frame is correct.
